// File: rtl/ps2_host_controller_pkg.sv
// Shared definitions for the PS/2 host controller: state encoding, frame size,
// common keyboard command bytes and the frame parity helper.
package ps2_host_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RX        = 3'd1,
      ST_INHIBIT   = 3'd2,
      ST_REQ       = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } ps2_state_t;

   localparam int FRAME_BITS = 11;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

   // Odd parity: the parity bit makes the count of ones over data+parity odd.
   function automatic logic odd_parity(input logic [7:0] i_byte);
      return ~(^i_byte);
   endfunction

endpackage

// File: rtl/ps2_host_controller_sync_edge.sv
// Two-flop synchronizer for the PS/2 pads plus a registered falling-edge pulse
// on the clock line; the data output is delayed so it lines up with the pulse.
module ps2_host_controller_sync_edge (
   input  logic clock_in,
   input  logic reset,
   input  logic i_clk_pad,
   input  logic i_dat_pad,
   output logic o_clk_sync,
   output logic o_dat_sync,
   output logic o_fall
);

   logic r_clk_meta;
   logic r_clk_sync;
   logic r_clk_prev;
   logic r_dat_meta;
   logic r_dat_sync;
   logic r_dat_dly;
   logic r_fall;

   // Synchronizer chains and fall detection; idle bus level is high.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
         r_dat_dly  <= 1'b1;
         r_fall     <= 1'b0;
      end else begin
         r_clk_meta <= i_clk_pad;
         r_clk_sync <= r_clk_meta;
         r_clk_prev <= r_clk_sync;
         r_dat_meta <= i_dat_pad;
         r_dat_sync <= r_dat_meta;
         r_dat_dly  <= r_dat_sync;
         r_fall     <= r_clk_prev & ~r_clk_sync;
      end
   end

   assign o_clk_sync = r_clk_sync;
   assign o_dat_sync = r_dat_dly;
   assign o_fall     = r_fall;

endmodule

// File: rtl/ps2_host_controller.sv
// Half-duplex PS/2 host: receives device frames, sends host commands and owns
// the open-drain clock/data enables for one PS/2 port.
module ps2_host_controller
   import ps2_host_controller_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_error,
   output logic       busy
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES);
   localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

   ps2_state_t       r_state;
   ps2_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_bit_cnt;
   logic [9:0]       r_rx_shift;
   logic [9:0]       r_tx_frame;
   logic [7:0]       r_rx_data;
   logic             r_clk_oe;
   logic             r_dat_oe;
   logic             r_rx_valid;
   logic             r_rx_error;
   logic             r_tx_done;
   logic             r_tx_error;

   logic             w_clk_sync;
   logic             w_dat_sync;
   logic             w_fall;
   logic             w_rx_start;
   logic             w_accept;
   logic             w_timed;
   logic             w_timeout;
   logic             w_enter;
   logic [10:0]      w_frame;
   logic             w_frame_ok;
   logic             w_rx_ok;
   logic             w_rx_bad;
   logic             w_tx_ok;
   logic             w_tx_bad;

   ps2_host_controller_sync_edge u_sync (
      .clock_in   (clock_in),
      .reset      (reset),
      .i_clk_pad  (ps2_clk_in),
      .i_dat_pad  (ps2_dat_in),
      .o_clk_sync (w_clk_sync),
      .o_dat_sync (w_dat_sync),
      .o_fall     (w_fall)
   );

   assign w_rx_start = (r_state == ST_IDLE) && w_fall && !w_dat_sync;
   assign tx_ready   = (r_state == ST_IDLE) && !w_rx_start && !reset;
   assign w_accept   = tx_valid && tx_ready;
   assign w_timed    = (r_state == ST_RX) || (r_state == ST_REQ) || (r_state == ST_WAIT_IDLE);
   assign w_timeout  = w_timed && !w_fall && (r_cnt == TMO_LAST);
   assign w_enter    = (w_state_nxt != r_state);
   // Frame as it will look once the bit on the current fall is shifted in; bit 0 is the start bit.
   assign w_frame    = {w_dat_sync, r_rx_shift};
   assign w_frame_ok = !w_frame[0] && (^w_frame[9:1]) && w_frame[10];

   // State register.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and completion/error events.
   always_comb begin
      w_state_nxt = r_state;
      w_rx_ok     = 1'b0;
      w_rx_bad    = 1'b0;
      w_tx_ok     = 1'b0;
      w_tx_bad    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rx_start) begin
               w_state_nxt = ST_RX;
            end else if (w_accept) begin
               w_state_nxt = ST_INHIBIT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RX: begin
            if (w_timeout) begin
               w_rx_bad    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_fall && (r_bit_cnt == LAST_BIT)) begin
               w_rx_ok     = w_frame_ok;
               w_rx_bad    = !w_frame_ok;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RX;
            end
         end
         ST_INHIBIT: begin
            if (r_cnt == INH_LAST) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_state_nxt = ST_INHIBIT;
            end
         end
         ST_REQ: begin
            if (w_timeout) begin
               w_tx_bad    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_fall && (r_bit_cnt == LAST_BIT)) begin
               w_tx_bad    = w_dat_sync;
               w_state_nxt = w_dat_sync ? ST_IDLE : ST_WAIT_IDLE;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_WAIT_IDLE: begin
            if (w_timeout) begin
               w_tx_bad    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_clk_sync && w_dat_sync) begin
               w_tx_ok     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_WAIT_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Counters, shift registers and registered outputs.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_cnt      <= '0;
         r_bit_cnt  <= 4'd0;
         r_rx_shift <= 10'd0;
         r_tx_frame <= 10'd0;
         r_rx_data  <= 8'd0;
         r_clk_oe   <= 1'b0;
         r_dat_oe   <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_error <= 1'b0;
         r_tx_done  <= 1'b0;
         r_tx_error <= 1'b0;
      end else begin
         r_rx_valid <= w_rx_ok;
         r_rx_error <= w_rx_bad;
         r_tx_done  <= w_tx_ok;
         r_tx_error <= w_tx_bad;
         if (w_rx_ok) begin
            r_rx_data <= w_frame[8:1];
         end
         // The count includes the cycle being registered, so a timeout lands exactly
         // TIMEOUT_CYCLES after the fall; falls during INHIBIT are our own and ignored.
         if (w_enter || (w_fall && w_timed)) begin
            r_cnt <= CNT_ONE;
         end else if (r_state != ST_IDLE) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         if (w_enter) begin
            r_bit_cnt <= (w_state_nxt == ST_RX) ? 4'd1 : 4'd0;
         end else if (w_fall && ((r_state == ST_RX) || (r_state == ST_REQ))) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
         if (w_rx_start || ((r_state == ST_RX) && w_fall)) begin
            r_rx_shift <= w_frame[10:1];
         end
         if (w_accept) begin
            r_tx_frame <= {1'b1, odd_parity(tx_data), tx_data};
         end
         r_clk_oe <= (w_state_nxt == ST_INHIBIT);
         if (w_state_nxt == ST_INHIBIT) begin
            r_dat_oe <= (r_state == ST_INHIBIT) && (r_cnt == INH_PRE);
         end else if (w_state_nxt == ST_REQ) begin
            if (r_state != ST_REQ) begin
               r_dat_oe <= 1'b1;
            end else if (w_fall) begin
               r_dat_oe <= ~r_tx_frame[r_bit_cnt];
            end
         end else begin
            r_dat_oe <= 1'b0;
         end
      end
   end

   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;
   assign rx_valid   = r_rx_valid;
   assign rx_error   = r_rx_error;
   assign rx_data    = r_rx_data;
   assign tx_done    = r_tx_done;
   assign tx_error   = r_tx_error;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_host_controller.sv
// Directed bench for ps2_host_controller with a behavioural PS/2 device on a
// wired-AND bus; timings are scaled down so the run stays short.
module tb_ps2_host_controller;
   import ps2_host_controller_pkg::*;

   localparam int INH = 40;
   localparam int TMO = 600;
   localparam int H   = 20;
   localparam int SYNC_LAT = 3;

   logic       clock_in;
   logic       reset;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_error;
   logic       busy;

   logic dev_clk;
   logic dev_dat;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_rxv = 0, n_rxe = 0, n_txd = 0, n_txe = 0, n_cko = 0;
   int s_rxv, s_rxe, s_txd, s_txe, s_cko;
   int last_fall_cyc = 0;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_host_controller #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock_in   (clock_in),
      .reset      (reset),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_error   (rx_error),
      .busy       (busy)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   // Pulse and level monitors; the stimulus compares snapshot deltas.
   always @(posedge clock_in) begin
      cyc <= cyc + 1;
      if (rx_valid)   n_rxv <= n_rxv + 1;
      if (rx_error)   n_rxe <= n_rxe + 1;
      if (tx_done)    n_txd <= n_txd + 1;
      if (tx_error)   n_txe <= n_txe + 1;
      if (ps2_clk_oe) n_cko <= n_cko + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_rxv = n_rxv; s_rxe = n_rxe; s_txd = n_txd; s_txe = n_txe; s_cko = n_cko;
   endtask

   task automatic dev_bit(input logic b);
      dev_dat = b;
      tick(H);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      tick(H);
      dev_clk = 1'b1;
   endtask

   task automatic dev_frame(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) dev_bit(f[i]);
      dev_dat = 1'b1;
      tick(H);
   endtask

   task automatic wait_accept();
      for (int i = 0; i < 500 && !ps2_clk_oe; i++) tick(1);
      check("tx_accepted", 32'(ps2_clk_oe), 32'd1);
      tx_valid = 1'b0;
   endtask

   // Device side of a host-to-device transfer; bits[9:0] = data, parity, stop as read.
   task automatic dev_tx(input logic ack, output logic [9:0] bits);
      bits = 10'd0;
      for (int i = 0; i < 500 && !(ps2_dat_oe && !ps2_clk_oe); i++) tick(1);
      check("req_state", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
      for (int p = 0; p < 11; p++) begin
         if (p == 10) dev_dat = ~ack;
         tick(H);
         dev_clk = 1'b0;
         tick(H);
         if (p < 10) bits[p] = ps2_dat_in;
         dev_clk = 1'b1;
      end
      tick(H);
      dev_dat = 1'b1;
      tick(10);
   endtask

   initial begin
      logic [10:0] f;
      logic [9:0]  bits;
      int          dly;
      reset    = 1'b1;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tick(4);
      check("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, tx_done, tx_error,
                                  rx_valid, rx_error, busy}), 32'h0);
      check("reset_rx_data", 32'(rx_data), 32'h0);
      reset = 1'b0;
      tick(2);
      check("idle_ready", 32'({tx_ready, busy}), 32'b10);

      // 1: good frame 0x1C, parity 0
      snap();
      f = {1'b1, 1'b0, 8'h1C, 1'b0};
      dev_frame(f, 11);
      check("t1_rx_valid_cnt", 32'(n_rxv - s_rxv), 32'd1);
      check("t1_rx_error_cnt", 32'(n_rxe - s_rxe), 32'd0);
      check("t1_rx_data", 32'(rx_data), 32'h1C);
      check("t1_busy", 32'(busy), 32'd0);

      // 2: bad parity keeps the previous byte
      snap();
      f = {1'b1, 1'b1, 8'h1C, 1'b0};
      dev_frame(f, 11);
      check("t2_rx_error_cnt", 32'(n_rxe - s_rxe), 32'd1);
      check("t2_rx_valid_cnt", 32'(n_rxv - s_rxv), 32'd0);
      check("t2_rx_data", 32'(rx_data), 32'h1C);

      // 3: send 0xED with device ACK
      snap();
      tx_data  = PS2_CMD_SET_LED;
      tx_valid = 1'b1;
      wait_accept();
      dev_tx(1'b1, bits);
      check("t3_inhibit_len", 32'(n_cko - s_cko), 32'(INH));
      check("t3_data_bits", 32'(bits[7:0]), 32'hED);
      check("t3_parity", 32'(bits[8]), 32'd1);
      check("t3_stop", 32'(bits[9]), 32'd1);
      check("t3_tx_done_cnt", 32'(n_txd - s_txd), 32'd1);
      check("t3_tx_error_cnt", 32'(n_txe - s_txe), 32'd0);
      check("t3_busy", 32'(busy), 32'd0);

      // 4: no ACK
      snap();
      tx_valid = 1'b1;
      wait_accept();
      dev_tx(1'b0, bits);
      check("t4_tx_error_cnt", 32'(n_txe - s_txe), 32'd1);
      check("t4_tx_done_cnt", 32'(n_txd - s_txd), 32'd0);
      check("t4_lines_busy", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);

      // 5: device stalls after data bit 3; rx_error T cycles after the synced fall
      snap();
      f = {1'b1, 1'b0, 8'h1C, 1'b0};
      for (int i = 0; i < 5; i++) dev_bit(f[i]);
      dev_dat = 1'b1;
      dly = -1;
      for (int i = 0; i < TMO + 100; i++) begin
         tick(1);
         if (rx_error) begin
            dly = cyc - last_fall_cyc;
            break;
         end
      end
      check("t5_timeout_delay", 32'(dly), 32'(TMO + SYNC_LAT));
      tick(3);
      check("t5_rx_error_cnt", 32'(n_rxe - s_rxe), 32'd1);
      check("t5_rx_valid_cnt", 32'(n_rxv - s_rxv), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);

      // 6: RX start collides with tx_valid; RX wins, then TX goes out
      snap();
      f = {1'b1, 1'b1, 8'hAA, 1'b0};
      dev_dat = 1'b0;
      tick(H);
      dev_clk = 1'b0;
      tick(SYNC_LAT);
      tx_data  = PS2_CMD_ENABLE;
      tx_valid = 1'b1;
      #1;
      check("t6_ready_blocked", 32'(tx_ready), 32'd0);
      tick(1);
      check("t6_busy_rx", 32'({busy, ps2_clk_oe}), 32'b10);
      tick(H - SYNC_LAT - 1);
      dev_clk = 1'b1;
      for (int i = 1; i < 11; i++) dev_bit(f[i]);
      dev_dat = 1'b1;
      check("t6_rx_valid_cnt", 32'(n_rxv - s_rxv), 32'd1);
      check("t6_rx_data", 32'(rx_data), 32'hAA);
      wait_accept();
      dev_tx(1'b1, bits);
      check("t6_tx_bits", 32'(bits), 32'({1'b1, 1'b0, 8'hF4}));
      check("t6_tx_done_cnt", 32'(n_txd - s_txd), 32'd1);

      // Reset in the middle of INHIBIT releases the clock line on the next edge
      tx_data  = PS2_CMD_RESET;
      tx_valid = 1'b1;
      wait_accept();
      tick(10);
      check("t6_mid_inhibit", 32'(ps2_clk_oe), 32'd1);
      reset = 1'b1;
      tick(1);
      check("t6_reset_release", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
      reset = 1'b0;
      tick(2);
      check("t6_ready_after_reset", 32'(tx_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
